// File: rtl/adxl362_pkg.sv
// ============================================================================
// adxl362_pkg: state encoding, axis codes and default sample width shared by
// the ADXL362 sample sequencer. Rev 1.0
// ============================================================================
`default_nettype none

package adxl362_pkg;

  localparam int DATA_W_DEF = 12;

  localparam logic [1:0] AXIS_X = 2'd0;
  localparam logic [1:0] AXIS_Y = 2'd1;
  localparam logic [1:0] AXIS_Z = 2'd2;
  localparam logic [1:0] AXIS_T = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_X  = 3'd1,
    ST_REQ_Y  = 3'd2,
    ST_REQ_Z  = 3'd3,
    ST_REQ_T  = 3'd4,
    ST_COMMIT = 3'd5
  } seq_state_t;

  function automatic logic is_req_state(input seq_state_t s);
    is_req_state = (s == ST_REQ_X) || (s == ST_REQ_Y) ||
                   (s == ST_REQ_Z) || (s == ST_REQ_T);
  endfunction

  function automatic logic [1:0] state_axis(input seq_state_t s);
    logic [1:0] a;
    case (s)
      ST_REQ_Y: a = AXIS_Y;
      ST_REQ_Z: a = AXIS_Z;
      ST_REQ_T: a = AXIS_T;
      default:  a = AXIS_X;
    endcase
    state_axis = a;
  endfunction

  // Acquisition order X -> Y -> Z -> T -> COMMIT.
  function automatic seq_state_t next_after_ack(input seq_state_t s);
    seq_state_t n;
    case (s)
      ST_REQ_X: n = ST_REQ_Y;
      ST_REQ_Y: n = ST_REQ_Z;
      ST_REQ_Z: n = ST_REQ_T;
      ST_REQ_T: n = ST_COMMIT;
      default:  n = ST_IDLE;
    endcase
    next_after_ack = n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adxl362_sample_sequencer_if.sv
// ============================================================================
// adxl362_sample_sequencer_if: sample request/ack channel between the
// sequencer (master) and the sensor core (slave). Rev 1.0
// ============================================================================
`default_nettype none

interface adxl362_sample_sequencer_if
  import adxl362_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              smp_req;
  logic [1:0]        smp_axis;
  logic              smp_ack;
  logic [DATA_W-1:0] smp_data;

  modport master (output smp_req, output smp_axis, input smp_ack, input smp_data);
  modport slave  (input smp_req, input smp_axis, output smp_ack, output smp_data);
endinterface

`default_nettype wire

// File: rtl/adxl362_odr_sync.sv
// ============================================================================
// adxl362_odr_sync: 2-flop synchronizer for clk_odr plus rising-edge detector;
// o_tick is a one-cycle pulse 3 clk_sys cycles after the clk_odr edge. Rev 1.0
// ============================================================================
`default_nettype none

module adxl362_odr_sync (
  input  wire  clk_sys,
  input  wire  rst,
  input  wire  i_clk_odr,
  output logic o_tick
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;
  logic r_tick;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_meta   <= i_clk_odr;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
      r_tick   <= r_sync & ~r_sync_d;
    end
  end

  assign o_tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/adxl362_sample_sequencer.sv
// ============================================================================
// adxl362_sample_sequencer: on each ODR tick fetches X/Y/Z/TEMP samples and
// commits them atomically. Optional overrun flag: ADXL362_SEQ_OVERRUN_EN. Rev 1.0
// ============================================================================
`default_nettype none

module adxl362_sample_sequencer
  import adxl362_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ACK_TIMEOUT = 255
) (
  input  wire                        clk_sys,
  input  wire                        rst,
  input  wire                        i_clk_odr,
  input  wire                        i_enable,
  adxl362_sample_sequencer_if.master smp_if,
  output logic [DATA_W-1:0]          o_xdata,
  output logic [DATA_W-1:0]          o_ydata,
  output logic [DATA_W-1:0]          o_zdata,
  output logic [DATA_W-1:0]          o_tdata,
  output logic                       o_data_ready,
  input  wire                        i_status_rd,
  output logic                       o_err
`ifdef ADXL362_SEQ_OVERRUN_EN
  ,
  output logic                       o_overrun
`endif
);

  localparam logic [9:0] c_WAIT_LAST = 10'(ACK_TIMEOUT - 1);

  logic              w_tick;
  seq_state_t        r_state;
  seq_state_t        w_state_next;
  logic [9:0]        r_wait_cnt;
  logic              w_in_req;
  logic              w_capture;
  logic              w_commit;
  logic              w_timeout;
  logic              w_req;
  logic [1:0]        w_axis;
  logic [DATA_W-1:0] r_shd_x, r_shd_y, r_shd_z, r_shd_t;
  logic [DATA_W-1:0] r_xdata, r_ydata, r_zdata, r_tdata;
  logic              r_data_ready;
  logic              r_err;

  adxl362_odr_sync u_odr_sync (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .i_clk_odr (i_clk_odr),
    .o_tick    (w_tick)
  );

  always_ff @(posedge clk_sys) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Abort on enable loss takes priority over a coincident ack.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_commit     = 1'b0;
    w_timeout    = 1'b0;
    w_in_req     = is_req_state(r_state);
    w_req        = w_in_req;
    w_axis       = w_in_req ? state_axis(r_state) : AXIS_X;
    case (r_state)
      ST_IDLE: begin
        if (w_tick && i_enable) w_state_next = ST_REQ_X;
      end
      ST_REQ_X, ST_REQ_Y, ST_REQ_Z, ST_REQ_T: begin
        if (!i_enable) begin
          w_state_next = ST_IDLE;
        end else if (smp_if.smp_ack) begin
          w_capture    = 1'b1;
          w_state_next = next_after_ack(r_state);
        end else if (r_wait_cnt == c_WAIT_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        w_commit     = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign smp_if.smp_req  = w_req;
  assign smp_if.smp_axis = w_axis;

  always_ff @(posedge clk_sys) begin
    if (rst || !w_in_req || (w_state_next != r_state)) r_wait_cnt <= '0;
    else                                               r_wait_cnt <= r_wait_cnt + 10'd1;
  end

  always_ff @(posedge clk_sys) begin
    if (rst || w_timeout) begin
      r_shd_x <= '0;
      r_shd_y <= '0;
      r_shd_z <= '0;
      r_shd_t <= '0;
    end else if (w_capture) begin
      case (w_axis)
        AXIS_X: r_shd_x <= smp_if.smp_data;
        AXIS_Y: r_shd_y <= smp_if.smp_data;
        AXIS_Z: r_shd_z <= smp_if.smp_data;
        AXIS_T: r_shd_t <= smp_if.smp_data;
      endcase
    end
  end

  // Committed set and flags; a set in the same cycle as status_rd wins.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_xdata      <= '0;
      r_ydata      <= '0;
      r_zdata      <= '0;
      r_tdata      <= '0;
      r_data_ready <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_commit) begin
        r_xdata <= r_shd_x;
        r_ydata <= r_shd_y;
        r_zdata <= r_shd_z;
        r_tdata <= r_shd_t;
      end
      if (w_commit)         r_data_ready <= 1'b1;
      else if (i_status_rd) r_data_ready <= 1'b0;
      if (w_timeout)        r_err <= 1'b1;
      else if (i_status_rd) r_err <= 1'b0;
    end
  end

`ifdef ADXL362_SEQ_OVERRUN_EN
  logic r_overrun;

  always_ff @(posedge clk_sys) begin
    if (rst)                                                      r_overrun <= 1'b0;
    else if ((w_commit && r_data_ready) || (w_tick && r_state != ST_IDLE)) r_overrun <= 1'b1;
    else if (i_status_rd)                                         r_overrun <= 1'b0;
  end

  assign o_overrun = r_overrun;
`endif

  assign o_xdata      = r_xdata;
  assign o_ydata      = r_ydata;
  assign o_zdata      = r_zdata;
  assign o_tdata      = r_tdata;
  assign o_data_ready = r_data_ready;
  assign o_err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_adxl362_sample_sequencer.sv
// ============================================================================
// tb_adxl362_sample_sequencer: randomized scoreboard bench for the ADXL362
// sample sequencer (also builds with ADXL362_SEQ_OVERRUN_EN). Rev 1.0
// ============================================================================
`default_nettype none

module tb_adxl362_sample_sequencer;
  import adxl362_pkg::*;

  localparam int DW = 12;
  localparam int TO = 255;

  typedef logic [4*DW-1:0] set_t;

  logic          clk_sys = 1'b0;
  logic          rst = 1'b1;
  logic          clk_odr = 1'b0;
  logic          enable = 1'b0;
  logic          status_rd = 1'b0;
  logic [DW-1:0] xdata, ydata, zdata, tdata;
  logic          data_ready, err;
`ifdef ADXL362_SEQ_OVERRUN_EN
  logic          overrun;
`endif

  adxl362_sample_sequencer_if #(.DATA_W(DW)) sif ();

  adxl362_sample_sequencer #(.DATA_W(DW), .ACK_TIMEOUT(TO)) dut (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .i_clk_odr    (clk_odr),
    .i_enable     (enable),
    .smp_if       (sif),
    .o_xdata      (xdata),
    .o_ydata      (ydata),
    .o_zdata      (zdata),
    .o_tdata      (tdata),
    .o_data_ready (data_ready),
    .i_status_rd  (status_rd),
    .o_err        (err)
`ifdef ADXL362_SEQ_OVERRUN_EN
    ,
    .o_overrun    (overrun)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  set_t          sb_q[$];
  set_t          mon_exp;
  logic          prev_dr = 1'b0;
  logic [DW-1:0] g_val[4];
  int            g_dly[4];
  logic [DW-1:0] m_out[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every fresh data_ready must reveal the oldest predicted set.
  always @(negedge clk_sys) begin
    if (data_ready === 1'b1 && prev_dr !== 1'b1) begin
      chk("commit_pending", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        mon_exp = sb_q.pop_front();
        chk("commit_set", {tdata, zdata, ydata, xdata}, mon_exp);
      end
    end
    prev_dr = data_ready;
  end

  function automatic set_t model_set();
    return {m_out[3], m_out[2], m_out[1], m_out[0]};
  endfunction

  task automatic tick_odr(input int phase, output int unsigned t0);
    @(posedge clk_sys);
    #(phase);
    clk_odr = 1'b1;
    t0 = cyc;
  endtask

  task automatic wait_axis(input int ax);
    int n = 0;
    while (!(sif.smp_req === 1'b1 && sif.smp_axis === 2'(ax)) && n < 40) begin
      @(negedge clk_sys);
      n++;
    end
    chk("req_axis", {sif.smp_req, sif.smp_axis}, {1'b1, 2'(ax)});
  endtask

  // Behavioural sensor core: answers each axis after g_dly cycles, or
  // injects a timeout / enable abort / reset at the chosen axis.
  task automatic serve(input int hold_ax, input int abort_ax, input int rst_ax,
                       input bit rd_commit, input bit extra_tick);
    int n;
    for (int ax = 0; ax < 4; ax++) begin
      wait_axis(ax);
      if (!(sif.smp_req === 1'b1 && sif.smp_axis === 2'(ax))) return;
      clk_odr = (extra_tick && ax == 1);
      if (ax == rst_ax) begin
        rst = 1'b1;
        @(negedge clk_sys);
        rst = 1'b0;
        chk("rst_outputs", {xdata, ydata, zdata, tdata, data_ready, err, sif.smp_req, sif.smp_axis}, 64'd0);
        return;
      end
      if (ax == abort_ax) begin
        enable = 1'b0;
        @(negedge clk_sys);
        chk("abort_req_drop", sif.smp_req, 64'd0);
        enable = 1'b1;
        return;
      end
      if (ax == hold_ax) begin
        n = 0;
        while (sif.smp_req === 1'b1 && n < 400) begin
          n++;
          @(negedge clk_sys);
        end
        chk("timeout_wait_cycles", n, TO);
        chk("timeout_err", err, 64'd1);
        return;
      end
      for (int d = 0; d < g_dly[ax]; d++) @(negedge clk_sys);
      sif.smp_ack  = 1'b1;
      sif.smp_data = g_val[ax];
      @(negedge clk_sys);
      sif.smp_ack  = 1'b0;
      sif.smp_data = DW'($urandom);
    end
    if (rd_commit) begin
      status_rd = 1'b1;
      @(negedge clk_sys);
      status_rd = 1'b0;
    end
  endtask

  task automatic run_set(input int phase, input bit rd_commit, input bit extra_tick);
    int unsigned t0;
    int          n;
    int          dsum = 0;
    for (int ax = 0; ax < 4; ax++) dsum += g_dly[ax];
    sb_q.push_back({g_val[3], g_val[2], g_val[1], g_val[0]});
    m_out = g_val;
    tick_odr(phase, t0);
    serve(-1, -1, -1, rd_commit, extra_tick);
    n = 0;
    while (data_ready !== 1'b1 && n < 6) begin
      @(negedge clk_sys);
      n++;
    end
    chk("data_ready_set", data_ready, 64'd1);
    // 3 cycles of synchronizer plus 6 of acquisition, stretched by ack waits.
    chk("tick_to_ready_latency", cyc - t0, 9 + dsum);
    if (extra_tick) begin
      n = 0;
      repeat (12) begin
        @(negedge clk_sys);
        if (sif.smp_req === 1'b1) n++;
      end
      chk("tick_outside_idle_ignored", n, 0);
`ifdef ADXL362_SEQ_OVERRUN_EN
      chk("overrun_tick_busy", overrun, 64'd1);
`endif
    end
    clk_odr   = 1'b0;
    status_rd = 1'b1;
    @(negedge clk_sys);
    status_rd = 1'b0;
    chk("data_ready_cleared", data_ready, 64'd0);
`ifdef ADXL362_SEQ_OVERRUN_EN
    chk("overrun_cleared", overrun, 64'd0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int unsigned t0;
    int          n;
    sif.smp_ack  = 1'b0;
    sif.smp_data = '0;
    for (int ax = 0; ax < 4; ax++) m_out[ax] = '0;
    repeat (3) @(negedge clk_sys);
    chk("reset_state", {xdata, ydata, zdata, tdata, data_ready, err, sif.smp_req, sif.smp_axis}, 64'd0);
    rst    = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Directed set with immediate acks and known values.
    g_val[0] = 12'h123; g_val[1] = 12'h456; g_val[2] = 12'h789; g_val[3] = 12'h0AB;
    for (int ax = 0; ax < 4; ax++) g_dly[ax] = 0;
    run_set(2, 1'b0, 1'b0);
    chk("directed_outputs", {tdata, zdata, ydata, xdata}, 64'h0AB_789_456_123);

    // status_rd coinciding with COMMIT.
    for (int ax = 0; ax < 4; ax++) g_val[ax] = DW'($urandom);
    run_set(4, 1'b1, 1'b0);

    // Tick while in standby is ignored.
    enable = 1'b0;
    tick_odr(3, t0);
    n = 0;
    repeat (12) begin
      @(negedge clk_sys);
      if (sif.smp_req === 1'b1) n++;
    end
    chk("standby_tick_ignored", n, 0);
    clk_odr = 1'b0;
    repeat (4) @(negedge clk_sys);
    enable = 1'b1;

    // Ack withheld on Y: timeout, outputs untouched, err cleared by status_rd.
    for (int ax = 0; ax < 4; ax++) g_val[ax] = DW'($urandom);
    tick_odr(5, t0);
    serve(1, -1, -1, 1'b0, 1'b0);
    clk_odr = 1'b0;
    chk("timeout_idle", sif.smp_req, 64'd0);
    chk("timeout_keeps_outputs", {tdata, zdata, ydata, xdata}, model_set());
    chk("timeout_no_ready", data_ready, 64'd0);
    status_rd = 1'b1;
    @(negedge clk_sys);
    status_rd = 1'b0;
    chk("err_cleared", err, 64'd0);

    // Enable dropped in REQ_Z: no commit.
    for (int ax = 0; ax < 4; ax++) g_val[ax] = DW'($urandom);
    tick_odr(6, t0);
    serve(-1, 2, -1, 1'b0, 1'b0);
    clk_odr = 1'b0;
    repeat (10) @(negedge clk_sys);
    chk("abort_no_ready", data_ready, 64'd0);
    chk("abort_keeps_outputs", {tdata, zdata, ydata, xdata}, model_set());

    // Randomized sets.
    for (int it = 0; it < 10; it++) begin
      bit xt;
      for (int ax = 0; ax < 4; ax++) begin
        g_val[ax] = DW'($urandom);
        g_dly[ax] = $urandom_range(0, 4);
      end
      xt = 1'($urandom_range(0, 1));
      if (xt) g_dly[1] = 6;
      run_set($urandom_range(1, 8), 1'($urandom_range(0, 1)), xt);
    end

    // Reset in REQ_T discards the set; the next tick starts again at X.
    for (int ax = 0; ax < 4; ax++) g_val[ax] = DW'($urandom);
    tick_odr(3, t0);
    serve(-1, -1, 3, 1'b0, 1'b0);
    clk_odr = 1'b0;
    for (int ax = 0; ax < 4; ax++) m_out[ax] = '0;
    repeat (4) @(negedge clk_sys);
    for (int ax = 0; ax < 4; ax++) begin
      g_val[ax] = DW'($urandom);
      g_dly[ax] = 0;
    end
    run_set(7, 1'b0, 1'b0);

`ifdef ADXL362_SEQ_OVERRUN_EN
    // Two sets without a status read raise overrun.
    for (int ax = 0; ax < 4; ax++) g_val[ax] = DW'($urandom);
    sb_q.push_back({g_val[3], g_val[2], g_val[1], g_val[0]});
    tick_odr(2, t0);
    serve(-1, -1, -1, 1'b0, 1'b0);
    clk_odr = 1'b0;
    repeat (4) @(negedge clk_sys);
    chk("ovr_first_no_overrun", overrun, 64'd0);
    for (int ax = 0; ax < 4; ax++) g_val[ax] = DW'($urandom);
    m_out = g_val;
    tick_odr(2, t0);
    serve(-1, -1, -1, 1'b0, 1'b0);
    clk_odr = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("ovr_second_set", {tdata, zdata, ydata, xdata}, model_set());
    chk("ovr_overrun_set", overrun, 64'd1);
    status_rd = 1'b1;
    @(negedge clk_sys);
    status_rd = 1'b0;
    chk("ovr_overrun_cleared", overrun, 64'd0);
    chk("ovr_ready_cleared", data_ready, 64'd0);
`endif

    repeat (4) @(negedge clk_sys);
    chk("scoreboard_drained", sb_q.size(), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
